// File: rtl/mul_iter_unit_pkg.sv
// Shared types and signedness helpers for the iterative RISC-V M-extension multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } mul_state_e;

    function automatic logic op_rs1_signed(input mul_op_e op);
        return op != MULHU;
    endfunction

    function automatic logic op_rs2_signed(input mul_op_e op);
        return (op == MUL) || (op == MULH);
    endfunction

endpackage

// File: rtl/mul_iter_unit_if.sv
// Issue-side request and writeback-side result handshakes of the multiplier.
interface mul_iter_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    import mul_pkg::*;

    logic             in_valid;
    logic             in_ready;
    mul_op_e          in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_rd;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_rd, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_rd, out_tag
    );

endinterface

// File: rtl/mul_iter_unit_step.sv
// One radix-2^K shift-add iteration over a 2*XLEN-bit unsigned accumulator.
module mul_step #(
    parameter int XLEN = 32,
    parameter int K    = 4
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [2*XLEN-1:0] mcand,
    input  logic [K-1:0]      mplier_slice,
    output logic [2*XLEN-1:0] acc_next
);

    assign acc_next = acc + mcand * {{(2*XLEN-K){1'b0}}, mplier_slice};

endmodule

// File: rtl/mul_iter_unit.sv
// Multi-cycle MUL/MULH/MULHSU/MULHU unit: sign-magnitude conversion, XLEN/K
// shift-add iterations, sign fix-up, then a held result until writeback accepts it.
module mul_iter_unit
    import mul_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int K     = 4,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    mul_iter_unit_if.slave mif
);

    localparam int ITERS = XLEN / K;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    if ((XLEN % K) != 0) begin : g_k_check
        $error("mul_iter_unit: XLEN must be a multiple of K");
    end

    mul_state_e        state;
    mul_state_e        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] corrected;
    logic [XLEN-1:0]   mplier;
    logic              neg;
    mul_op_e           op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   out_rd_q;
    logic [TAG_W-1:0]  out_tag_q;

    logic              accept;
    logic              rs1_neg;
    logic              rs2_neg;
    logic [XLEN-1:0]   rs1_mag;
    logic [XLEN-1:0]   rs2_mag;

    assign accept = mif.in_valid && (state == IDLE) && !flush;

    // The most-negative operand negates to itself, which read unsigned is exactly 2^(XLEN-1).
    assign rs1_neg = op_rs1_signed(mif.in_op) && mif.in_rs1[XLEN-1];
    assign rs2_neg = op_rs2_signed(mif.in_op) && mif.in_rs2[XLEN-1];
    assign rs1_mag = rs1_neg ? -mif.in_rs1 : mif.in_rs1;
    assign rs2_mag = rs2_neg ? -mif.in_rs2 : mif.in_rs2;

    assign corrected = neg ? -acc : acc;

    mul_step #(
        .XLEN (XLEN),
        .K    (K)
    ) u_step (
        .acc          (acc),
        .mcand        (mcand),
        .mplier_slice (mplier[K-1:0]),
        .acc_next     (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (cnt == LAST_ITER) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (mif.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            neg       <= 1'b0;
            op_q      <= MUL;
            tag_q     <= '0;
            out_rd_q  <= '0;
            out_tag_q <= '0;
        end else if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, rs1_mag};
            mplier <= rs2_mag;
            neg    <= rs1_neg ^ rs2_neg;
            op_q   <= mif.in_op;
            tag_q  <= mif.in_tag;
        end else if (state == BUSY && !flush) begin
            cnt    <= cnt + CNT_W'(1);
            acc    <= acc_next;
            mcand  <= mcand << K;
            mplier <= mplier >> K;
        end else if (state == FIX && !flush) begin
            out_rd_q  <= (op_q == MUL) ? corrected[XLEN-1:0] : corrected[2*XLEN-1:XLEN];
            out_tag_q <= tag_q;
        end
    end

    assign mif.in_ready  = (state == IDLE);
    assign mif.out_valid = (state == DONE);
    assign mif.out_rd    = out_rd_q;
    assign mif.out_tag   = out_tag_q;

endmodule
